// File: rtl/aes_enc_pipe.sv
// Fully pipelined AES-128 encryption core with an on-chip key schedule.
// The schedule expands one round key per cycle after a key_load pulse; once all
// round keys are valid, one plaintext block can be accepted per cycle and its
// ciphertext appears NR+1 edges later.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   key_load  - one-cycle pulse: capture key_in, restart expansion, flush pipe
//   key_in    - 128-bit cipher key, byte 0 = [127:120]
//   key_ready - all round keys valid; doubles as input-ready
//   in_valid  - plaintext strobe, taken only while key_ready=1 and no key_load
//   in_data   - plaintext, column-major state, byte 0 = [127:120]
//   out_valid - one-cycle strobe per accepted block
//   out_data  - ciphertext, held between strobes
module aes_enc_pipe #(
  parameter int unsigned BLOCK_LENGTH = 128,
  parameter int unsigned NR           = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_load,
  input  logic [BLOCK_LENGTH-1:0] key_in,
  output logic                    key_ready,
  input  logic                    in_valid,
  input  logic [BLOCK_LENGTH-1:0] in_data,
  output logic                    out_valid,
  output logic [BLOCK_LENGTH-1:0] out_data
);

  localparam int unsigned CW = $clog2(NR + 1);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } key_st_e;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8), reduction polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [CW-1:0] i);
    logic [7:0] r;
    case (i)
      CW'(1):  r = 8'h01;
      CW'(2):  r = 8'h02;
      CW'(3):  r = 8'h04;
      CW'(4):  r = 8'h08;
      CW'(5):  r = 8'h10;
      CW'(6):  r = 8'h20;
      CW'(7):  r = 8'h40;
      CW'(8):  r = 8'h80;
      CW'(9):  r = 8'h1b;
      CW'(10): r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // One key-schedule step: RotWord, SubWord, Rcon on word 0, then chained XOR.
  function automatic logic [127:0] key_next(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] t;
    logic [31:0] n0;
    logic [31:0] n1;
    logic [31:0] n2;
    logic [31:0] n3;
    t  = sub_word({prev[23:0], prev[31:24]}) ^ {rc, 24'h000000};
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64] ^ n0;
    n2 = prev[63:32] ^ n1;
    n3 = prev[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // SubBytes + ShiftRows; byte 4c+r is row r, column c.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] res;
    logic [7:0]   a0;
    logic [7:0]   a1;
    logic [7:0]   a2;
    logic [7:0]   a3;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      res[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      res[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      res[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      res[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return res;
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] t;
    t = sub_shift(s);
    if (!last) t = mix_columns(t);
    return t ^ rk;
  endfunction

  key_st_e                 state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    key_ready_q, key_ready_d;
  logic [BLOCK_LENGTH-1:0] rk_q [0:NR];
  logic                    rk_we;
  logic [CW-1:0]           rk_idx;
  logic [BLOCK_LENGTH-1:0] rk_wdata;
  logic [BLOCK_LENGTH-1:0] rk_prev;

  logic [NR:0]             vld_q;
  logic [BLOCK_LENGTH-1:0] st_q [0:NR];
  logic [BLOCK_LENGTH-1:0] rnd_d [1:NR];
  logic                    accept_c;

  // Previous round key feeding the expansion step.
  always_comb begin
    rk_prev = rk_q[0];
    for (int unsigned i = 1; i <= NR; i++) begin
      if (cnt_q == CW'(i)) rk_prev = rk_q[i-1];
    end
  end

  // Key FSM: next state, counter and round-key write port.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_ready_d = key_ready_q;
    rk_we       = 1'b0;
    rk_idx      = cnt_q;
    rk_wdata    = key_next(rk_prev, rcon(cnt_q));
    if (key_load) begin
      state_d     = EXPAND;
      cnt_d       = CW'(1);
      key_ready_d = 1'b0;
      rk_we       = 1'b1;
      rk_idx      = '0;
      rk_wdata    = key_in;
    end else begin
      case (state_q)
        EXPAND: begin
          rk_we = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(NR)) begin
            state_d     = READY;
            key_ready_d = 1'b1;
            cnt_d       = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Key FSM and round-key registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_ready_q <= 1'b0;
      for (int unsigned i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_ready_q <= key_ready_d;
      for (int unsigned i = 0; i <= NR; i++) begin
        if (rk_we && rk_idx == CW'(i)) rk_q[i] <= rk_wdata;
      end
    end
  end

  // A key_load on the same edge wins over the block.
  assign accept_c = in_valid & key_ready_q & ~key_load;

  // Round logic for stages 1..NR; the last stage skips MixColumns.
  always_comb begin
    for (int unsigned i = 1; i <= NR; i++) begin
      rnd_d[i] = enc_round(st_q[i-1], rk_q[i], i == NR);
    end
  end

  // Pipeline: valid bits shift every edge and are cleared by key_load;
  // data only moves with a valid so out_data holds between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i <= NR; i++) st_q[i] <= '0;
    end else begin
      vld_q[0] <= accept_c;
      if (accept_c) st_q[0] <= in_data ^ rk_q[0];
      for (int unsigned i = 1; i <= NR; i++) begin
        vld_q[i] <= vld_q[i-1] & ~key_load;
        if (vld_q[i-1] && !key_load) st_q[i] <= rnd_d[i];
      end
    end
  end

  assign key_ready = key_ready_q;
  assign out_valid = vld_q[NR];
  assign out_data  = st_q[NR];

endmodule

// File: tb/tb_aes_enc_pipe.sv
// Bench for aes_enc_pipe: byte-oriented AES reference model with an S-box
// derived from GF(2^8) inversion, a scoreboard of expected ciphertexts with
// their due cycle, a vector table, and sequences for reload and reset.
module tb_aes_enc_pipe;

  logic         clk;
  logic         rst;
  logic         key_load;
  logic [127:0] key_in;
  logic         key_ready;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_valid;
  logic [127:0] out_data;

  aes_enc_pipe #(.BLOCK_LENGTH(128), .NR(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_load (key_load),
    .key_in   (key_in),
    .key_ready(key_ready),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int n_out  = 0;

  typedef struct {
    logic [127:0] ct;
    int           due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;
  vec_t tbl[4];

  logic [7:0] m_sbox[256];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w[44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s[4][4];
    logic [7:0]   n[4][4];
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          n[r][c] = m_sbox[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[0][c] = gmul(8'h02, n[0][c]) ^ gmul(8'h03, n[1][c]) ^ n[2][c] ^ n[3][c];
          s[1][c] = n[0][c] ^ gmul(8'h02, n[1][c]) ^ gmul(8'h03, n[2][c]) ^ n[3][c];
          s[2][c] = n[0][c] ^ n[1][c] ^ gmul(8'h02, n[2][c]) ^ gmul(8'h03, n[3][c]);
          s[3][c] = gmul(8'h03, n[0][c]) ^ n[1][c] ^ n[2][c] ^ gmul(8'h02, n[3][c]);
        end else begin
          for (int r = 0; r < 4; r++) s[r][c] = n[r][c];
        end
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
      end
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- output monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst && out_valid) begin
      n_out++;
      if (sb.size() == 0) begin
        chk("spurious_out_valid", {127'b0, out_valid}, 128'h0);
      end else begin
        e = sb.pop_front();
        chk("ciphertext", out_data, e.ct);
        chk("latency", 128'(cyc), 128'(e.due));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] ct, input bit push);
    exp_t e;
    in_valid = 1'b1;
    in_data  = pt;
    if (push) begin
      e.ct  = ct;
      e.due = cyc + 11;
      sb.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // key_load pulse, then 10 edges of expansion; optionally pokes in_valid
  // on the load edge and during expansion, none of which may be accepted.
  task automatic load_key(input logic [127:0] key, input bit timing, input bit poke);
    key_in   = key;
    key_load = 1'b1;
    in_valid = poke;
    in_data  = rnd128();
    tick();
    sb.delete();
    key_load = 1'b0;
    in_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      in_valid = poke && (i % 2 == 1);
      in_data  = rnd128();
      tick();
      in_valid = 1'b0;
      if (timing || i == 10)
        chk($sformatf("key_ready_edge%0d", i), {127'b0, key_ready}, {127'b0, (i == 10)});
    end
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    logic [127:0] cur_key;
    logic [127:0] k3;
    logic [127:0] pt;
    int           n0;

    rst = 1'b0; key_load = 1'b0; key_in = '0; in_valid = 1'b0; in_data = '0;
    build_sbox();
    repeat (3) tick();
    chk("reset_key_ready", {127'b0, key_ready}, 128'h0);
    chk("reset_out_valid", {127'b0, out_valid}, 128'h0);
    chk("reset_out_data", out_data, 128'h0);
    rst = 1'b1;
    tick();

    // Key schedule timing and final round key.
    load_key(K1, 1'b1, 1'b0);
    chk("rk10", dut.rk_q[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    cur_key = K1;

    // Vector table: one block per entry, exactly one out_valid each.
    tbl[0] = '{key: K1, pt: PT1, ct: CT1};
    tbl[1] = '{key: K2, pt: PT2, ct: CT2};
    tbl[2].key = K2;       tbl[2].pt = rnd128(); tbl[2].ct = aes_model(tbl[2].key, tbl[2].pt);
    tbl[3].key = rnd128(); tbl[3].pt = rnd128(); tbl[3].ct = aes_model(tbl[3].key, tbl[3].pt);
    for (int v = 0; v < 4; v++) begin
      if (tbl[v].key != cur_key) begin
        load_key(tbl[v].key, 1'b0, 1'b0);
        cur_key = tbl[v].key;
      end
      n0 = n_out;
      send(tbl[v].pt, tbl[v].ct, 1'b1);
      drain(13);
      chk($sformatf("vec%0d_out_count", v), 128'(n_out - n0), 128'd1);
    end

    // Back-to-back stream of 8 under K2.
    load_key(K2, 1'b0, 1'b0);
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) send(PT2, CT2, 1'b1);
      else begin
        pt = rnd128();
        send(pt, aes_model(K2, pt), 1'b1);
      end
    end
    drain(14);
    chk("stream_out_count", 128'(n_out - n0), 128'd8);

    // Inputs offered during expansion are ignored.
    n0 = n_out;
    load_key(K1, 1'b0, 1'b1);
    drain(14);
    chk("early_input_no_out", 128'(n_out - n0), 128'd0);

    // Reload with 5 blocks in flight: all dropped, new key used afterwards.
    for (int i = 0; i < 5; i++) begin
      pt = rnd128();
      send(pt, aes_model(K1, pt), 1'b1);
    end
    n0 = n_out;
    k3 = rnd128();
    load_key(k3, 1'b0, 1'b1);
    chk("reload_old_dropped", 128'(n_out - n0), 128'd0);
    n0 = n_out;
    for (int i = 0; i < 3; i++) begin
      pt = rnd128();
      send(pt, aes_model(k3, pt), 1'b1);
    end
    drain(14);
    chk("reload_new_out_count", 128'(n_out - n0), 128'd3);

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 13; i++) begin
      pt = rnd128();
      send(pt, aes_model(k3, pt), 1'b1);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("areset_key_ready", {127'b0, key_ready}, 128'h0);
    chk("areset_out_valid", {127'b0, out_valid}, 128'h0);
    chk("areset_out_data", out_data, 128'h0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    n0 = n_out;
    send(rnd128(), '0, 1'b0);
    send(rnd128(), '0, 1'b0);
    drain(14);
    chk("post_reset_key_ready", {127'b0, key_ready}, 128'h0);
    chk("post_reset_no_out", 128'(n_out - n0), 128'd0);

    // Recovery after a fresh key load.
    load_key(K2, 1'b0, 1'b0);
    n0 = n_out;
    send(PT2, CT2, 1'b1);
    drain(13);
    chk("recover_out_count", 128'(n_out - n0), 128'd1);
    chk("scoreboard_empty", 128'(sb.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_enc_pipe.md
Name: aes_enc_pipe

Overview:
- Fully pipelined AES-128 encryption core, FIPS-197; the encrypt-side counterpart of the team's pipelined decryption top.
- Holds an on-chip key schedule, expanded iteratively by an internal FSM: one round key per cycle.
- Accepts one plaintext block per cycle and returns ciphertext after a fixed latency.
- Sits beside the decryption core in the AES subsystem and shares its key-load and valid conventions.

Parameters:
BLOCK_LENGTH, 128, block and key width in bits; only 128 is supported.
NR, 10, number of rounds; fixed for AES-128.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
key_load  input  1  single-cycle pulse; captures key_in and starts key expansion.
key_in  input  128  cipher key; byte 0 = bits [127:120].
key_ready  output  1  high when all 11 round keys are valid; also acts as in_ready.
in_valid  input  1  plaintext strobe; accepted only when key_ready=1 on the same edge.
in_data  input  128  plaintext; state loaded column-major, byte 0 = bits [127:120].
out_valid  output  1  one-cycle strobe per accepted block.
out_data  output  128  ciphertext; same byte order as in_data.

Behaviour:
- Reset (rst=0, asynchronous):
  - key_ready=0, out_valid=0, out_data=0.
  - All valid pipeline bits=0; all stage registers=0.
  - FSM=IDLE; round-key registers=0.
- Key FSM states: IDLE, EXPAND, READY.
  - Any state, key_load=1 at an edge: rk[0]<=key_in, cnt<=1, state<=EXPAND, key_ready<=0.
  - EXPAND, each edge: rk[cnt] <= next(rk[cnt-1], Rcon[cnt]), cnt<=cnt+1.
    - next() = RotWord, SubWord, XOR Rcon on word 0, then the chained XOR.
    - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
  - EXPAND with cnt=10: rk[10] written, state<=READY, key_ready<=1.
  - Result: key_ready rises exactly 10 edges after the edge that sampled key_load.
  - key_load during EXPAND: restart from the new key. Partially expanded keys are discarded.
  - key_load in READY: key_ready drops on that edge.
- Flush on key_load: every valid pipeline bit and out_valid clears on the same edge. In-flight blocks are dropped, never emitted with mixed keys.
- Input acceptance:
  - in_valid=1 and key_ready=1: block accepted.
  - in_valid with key_ready=0: silently ignored; nothing enters the pipeline.
  - in_valid and key_load on the same edge: the key_load wins; the block is ignored.
- Datapath: 11 registered stages, each with a valid bit shifted alongside the data.
  - Stage 0: state XOR rk[0].
  - Stages 1..9: SubBytes, ShiftRows, MixColumns, then XOR rk[i].
  - Stage 10: SubBytes, ShiftRows, XOR rk[10]; no MixColumns.
  - Stage data registers load only when their incoming valid bit is 1; otherwise they hold.
- Latency and throughput:
  - Block accepted at edge N: out_valid=1 for the cycle following edge N+10, i.e. 11 edges from acceptance.
  - Back-to-back acceptance gives one output per cycle, in order, with no bubbles.
- Outputs:
  - out_data holds the last ciphertext while out_valid=0.
  - No backpressure: the consumer must take every out_valid.
- Arithmetic: GF(2^8) xtime uses reduction polynomial 0x11b. All XORs are bitwise; there is no carry.

Test Plan:
- Key schedule: reset, key_load with key 2b7e151628aed2a6abf7158809cf4f3c.
  - key_ready rises exactly 10 cycles after the load edge.
  - rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Single block, same key: plaintext 3243f6a8885a308d313198a2e0370734.
  - out_valid one cycle, 11 edges after acceptance.
  - out_data = 3925841d02dc09fbdc118597196a0b32.
- Back-to-back stream: key 000102030405060708090a0b0c0d0e0f.
  - 8 consecutive blocks, including 00112233445566778899aabbccddeeff.
  - 8 contiguous out_valid cycles in order; that block yields 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Other blocks checked against the reference model.
- Early input: in_valid pulsed during EXPAND → no out_valid ever results from it.
- Reload mid-flight: 5 blocks in flight, then key_load with a new key.
  - No out_valid from the old blocks.
  - Only post-key_ready blocks emerge, encrypted with the new key.
- Async reset mid-stream: rst low for a partial cycle.
  - All outputs are 0 immediately.
  - After release, key_ready stays 0 until a new key_load.
